// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: FSM state encoding and the
// per-access flags captured when a request is accepted.
package mem_access_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic write;
    logic byte_acc;
    logic fetch;
  } acc_flags_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the register file and the bus: byte enables,
// write-byte replication across lanes and zero-extended read-lane extraction.
module mem_lane_align #(
  parameter int unsigned WORD = 16,
  localparam int unsigned LANES = WORD / 8,
  localparam int unsigned LSB = $clog2(LANES)
) (
  input  logic             byte_acc,
  input  logic             wr_byte,
  input  logic [LSB-1:0]   lane,
  input  logic [WORD-1:0]  wdata,
  input  logic [WORD-1:0]  rdata,
  output logic [LANES-1:0] be,
  output logic [WORD-1:0]  wdata_al,
  output logic [WORD-1:0]  rdata_al
);

  always_comb begin
    be       = '1;
    wdata_al = wdata;
    rdata_al = rdata;
    if (byte_acc) begin
      be       = '0;
      rdata_al = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane == LSB'(i)) begin
          be[i]         = 1'b1;
          rdata_al[7:0] = rdata[i*8 +: 8];
        end
      end
    end
    if (wr_byte) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        wdata_al[i*8 +: 8] = wdata[7:0];
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: latches one request into MAR/OMDR, drives a single bus
// transaction with a bounded wait, and returns read data into IMDR/IR.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned WORD   = 16,
  parameter int unsigned TO_CYC = 15,
  localparam int unsigned LANES = WORD / 8,
  localparam int unsigned LSB   = $clog2(LANES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             write_i,
  input  logic             byte_i,
  input  logic             fetch_i,
  input  logic [WORD-1:0]  addr_i,
  input  logic [WORD-1:0]  wdata_i,
  output logic             busreq_o,
  output logic             buswr_o,
  output logic [LANES-1:0] busbe_o,
  output logic [WORD-1:0]  busaddr_o,
  output logic [WORD-1:0]  buswdata_o,
  input  logic             busack_i,
  input  logic [WORD-1:0]  busrdata_i,
  output logic [WORD-1:0]  mar_o,
  output logic [WORD-1:0]  imdr_o,
  output logic [WORD-1:0]  omdr_o,
  output logic [WORD-1:0]  ir_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned CW = $clog2(TO_CYC + 1);
  localparam logic [WORD-1:0] ADDR_MASK = ~(WORD'(LANES - 1));

  state_e          state_q, state_d;
  acc_flags_t      flags_q, flags_d, flags_start;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WORD-1:0] mar_q, mar_d;
  logic [WORD-1:0] imdr_q, imdr_d;
  logic [WORD-1:0] omdr_q, omdr_d;
  logic [WORD-1:0] ir_q, ir_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [LANES-1:0] lane_be;
  logic [WORD-1:0]  wdata_al;
  logic [WORD-1:0]  rdata_al;

  mem_lane_align #(
    .WORD(WORD)
  ) u_align (
    .byte_acc (flags_q.byte_acc),
    .wr_byte  (byte_i),
    .lane     (mar_q[LSB-1:0]),
    .wdata    (wdata_i),
    .rdata    (busrdata_i),
    .be       (lane_be),
    .wdata_al (wdata_al),
    .rdata_al (rdata_al)
  );

  // Fetch only qualifies reads, and a fetch always forces a word access.
  always_comb begin
    flags_start.write    = write_i;
    flags_start.fetch    = fetch_i & ~write_i;
    flags_start.byte_acc = byte_i & ~(fetch_i & ~write_i);
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    imdr_d  = imdr_q;
    omdr_d  = omdr_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACCESS;
          flags_d = flags_start;
          mar_d   = addr_i;
          cnt_d   = '0;
          if (write_i) omdr_d = wdata_al;
        end
      end
      S_ACCESS: begin
        if (busack_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!flags_q.write) begin
            imdr_d = rdata_al;
            if (flags_q.fetch) ir_d = busrdata_i;
          end
        end else if (cnt_q == CW'(TO_CYC - 1)) begin
          // Last permitted wait cycle without ack: give up.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      cnt_q   <= '0;
      mar_q   <= '0;
      imdr_q  <= '0;
      omdr_q  <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      imdr_q  <= imdr_d;
      omdr_q  <= omdr_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o     = (state_q == S_ACCESS);
  assign busreq_o   = busy_o;
  assign buswr_o    = busy_o & flags_q.write;
  assign busbe_o    = busy_o ? lane_be : '0;
  assign busaddr_o  = flags_q.byte_acc ? mar_q : (mar_q & ADDR_MASK);
  assign buswdata_o = omdr_q;
  assign mar_o      = mar_q;
  assign imdr_o     = imdr_q;
  assign omdr_o     = omdr_q;
  assign ir_o       = ir_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions compared against a transaction-level model of the registers.
module tb_mem_access_unit;

  localparam int WORD   = 16;
  localparam int TO_CYC = 15;
  localparam int LANES  = WORD / 8;

  logic             clk = 1'b0;
  logic             rst, start, wr, byt, fetch, ack;
  logic [WORD-1:0]  addr, wdata, rdata;
  logic             busreq, buswr, busy, done, err;
  logic [LANES-1:0] busbe;
  logic [WORD-1:0]  busaddr, buswdata, mar, imdr, omdr, ir;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WORD-1:0] m_mar, m_imdr, m_omdr, m_ir;

  always #5 clk = ~clk;

  mem_access_unit #(
    .WORD   (WORD),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .write_i    (wr),
    .byte_i     (byt),
    .fetch_i    (fetch),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busreq_o   (busreq),
    .buswr_o    (buswr),
    .busbe_o    (busbe),
    .busaddr_o  (busaddr),
    .buswdata_o (buswdata),
    .busack_i   (ack),
    .busrdata_i (rdata),
    .mar_o      (mar),
    .imdr_o     (imdr),
    .omdr_o     (omdr),
    .ir_o       (ir),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".mar"},  mar,  m_mar);
    check_eq({tag, ".imdr"}, imdr, m_imdr);
    check_eq({tag, ".omdr"}, omdr, m_omdr);
    check_eq({tag, ".ir"},   ir,   m_ir);
  endtask

  // Entered before the edge that must accept the request; returns at the
  // negedge of the done/err cycle. ack_k = 0 means never acknowledge.
  task automatic run_txn(input bit w, input bit b, input bit f,
                         input logic [WORD-1:0] a, input logic [WORD-1:0] wd,
                         input int ack_k, input logic [WORD-1:0] rd);
    bit               fe, bacc, acked;
    int               lane;
    logic [WORD-1:0]  e_addr;
    logic [LANES-1:0] e_be;
    fe    = f && !w;
    bacc  = b && !fe;
    acked = 1'b0;
    lane  = int'(a) % LANES;
    start = 1'b1; wr = w; byt = b; fetch = f; addr = a; wdata = wd;
    m_mar = a;
    if (w) begin
      if (bacc) for (int i = 0; i < LANES; i++) m_omdr[i*8 +: 8] = wd[7:0];
      else m_omdr = wd;
    end
    e_addr = bacc ? a : a - WORD'(lane);
    e_be   = bacc ? LANES'(1 << lane) : '1;
    @(posedge clk); #1;
    for (int k = 1; k <= TO_CYC; k++) begin
      // Unrelated start requests during the access must be ignored.
      start = 1'($urandom); wr = 1'($urandom); byt = 1'($urandom);
      fetch = 1'($urandom); addr = WORD'($urandom); wdata = WORD'($urandom);
      ack   = (k == ack_k);
      rdata = (k == ack_k) ? rd : WORD'($urandom);
      @(negedge clk);
      check_eq("acc.busreq",   busreq,   1);
      check_eq("acc.busy",     busy,     1);
      check_eq("acc.busaddr",  busaddr,  e_addr);
      check_eq("acc.busbe",    busbe,    e_be);
      check_eq("acc.buswr",    buswr,    w);
      check_eq("acc.buswdata", buswdata, m_omdr);
      check_eq("acc.done",     done,     0);
      check_eq("acc.err",      err,      0);
      @(posedge clk); #1;
      if (k == ack_k) begin
        acked = 1'b1;
        break;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    if (acked && !w) begin
      m_imdr = bacc ? ((rd >> (8 * lane)) & WORD'(8'hFF)) : rd;
      if (fe) m_ir = rd;
    end
    @(negedge clk);
    check_eq("end.done",   done,   acked);
    check_eq("end.err",    err,    !acked);
    check_eq("end.busreq", busreq, 0);
    check_eq("end.busbe",  busbe,  0);
    check_eq("end.buswr",  buswr,  0);
    check_eq("end.busy",   busy,   0);
    check_regs("end");
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0;
    ack   = 1'($urandom);
    rdata = WORD'($urandom);
    @(negedge clk);
    check_eq("idle.busreq", busreq, 0);
    check_eq("idle.busbe",  busbe,  0);
    check_eq("idle.done",   done,   0);
    check_eq("idle.err",    err,    0);
    check_regs("idle");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr = 1'b0; byt = 1'b0; fetch = 1'b0;
    ack = 1'b0; addr = '0; wdata = '0; rdata = '0;
    m_mar = '0; m_imdr = '0; m_omdr = '0; m_ir = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst.busreq",   busreq,   0);
    check_eq("rst.buswr",    buswr,    0);
    check_eq("rst.busbe",    busbe,    0);
    check_eq("rst.busaddr",  busaddr,  0);
    check_eq("rst.buswdata", buswdata, 0);
    check_eq("rst.busy",     busy,     0);
    check_eq("rst.done",     done,     0);
    check_eq("rst.err",      err,      0);
    check_regs("rst");

    // Word read, ack after three wait cycles.
    run_txn(1'b0, 1'b0, 1'b0, 16'h1235, 16'h0000, 4, 16'hBEEF);
    check_eq("wread.imdr", imdr, 16'hBEEF);
    idle_cycle();

    // Byte write to odd lane: replicated data, IMDR untouched.
    run_txn(1'b1, 1'b1, 1'b0, 16'h0101, 16'h00A5, 1, 16'h1357);
    check_eq("bwrite.omdr", omdr, 16'hA5A5);
    check_eq("bwrite.imdr", imdr, 16'hBEEF);

    // Byte read at odd address, then a fetch back-to-back in the done cycle.
    run_txn(1'b0, 1'b1, 1'b0, 16'h0103, 16'h0000, 2, 16'h7F80);
    check_eq("bread.imdr", imdr, 16'h007F);
    run_txn(1'b0, 1'b1, 1'b1, 16'h0201, 16'h0000, 1, 16'h4C21);
    check_eq("fetch.ir",   ir,   16'h4C21);
    check_eq("fetch.imdr", imdr, 16'h4C21);

    // Timeout, then back-to-back access acked in the last allowed cycle.
    run_txn(1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 0, 16'h0000);
    check_eq("tout.imdr", imdr, 16'h4C21);
    run_txn(1'b0, 1'b0, 1'b0, 16'h4002, 16'h0000, TO_CYC, 16'h5A5A);
    idle_cycle();

    // Reset in the second access cycle; the following ack is ignored.
    start = 1'b1; wr = 1'b1; byt = 1'b0; fetch = 1'b0; addr = 16'h2222; wdata = 16'h3333;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ack = 1'b1; rdata = 16'hDEAD;
    m_mar = '0; m_imdr = '0; m_omdr = '0; m_ir = '0;
    @(negedge clk);
    check_eq("rmid.busreq",  busreq,  0);
    check_eq("rmid.busaddr", busaddr, 0);
    check_eq("rmid.done",    done,    0);
    check_eq("rmid.err",     err,     0);
    check_regs("rmid");
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    check_eq("rmid2.done",   done,   0);
    check_eq("rmid2.busreq", busreq, 0);
    check_regs("rmid2");

    for (int t = 0; t < 60; t++) begin
      int gap;
      int ak;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      ak = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TO_CYC);
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), WORD'($urandom),
              WORD'($urandom), ak, WORD'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WORD, default 16, datapath and address width; multiple of 8, >= 16.
REQ-002 Parameter TO_CYC, default 15, bus-wait timeout in cycles; >= 1.
REQ-003 Derived: LANES = WORD/8; LSB = clog2(LANES).
REQ-004 The unit uses one clock; reset is synchronous and active-high: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-005 start_i  input  1  access request from control unit.
REQ-006 write_i  input  1  1 = write, 0 = read; sampled with start_i.
REQ-007 byte_i  input  1  1 = byte access, 0 = word access; sampled with start_i.
REQ-008 fetch_i  input  1  read is an instruction fetch; sampled with start_i.
REQ-009 addr_i  input  WORD  access address.
REQ-010 wdata_i  input  WORD  write data; byte data in bits [7:0].
REQ-011 busreq_o  output  1  bus request.
REQ-012 buswr_o  output  1  bus write strobe qualifier.
REQ-013 busbe_o  output  LANES  byte enables.
REQ-014 busaddr_o  output  WORD  bus address.
REQ-015 buswdata_o  output  WORD  bus write data (OMDR).
REQ-016 busack_i  input  1  bus completion.
REQ-017 busrdata_i  input  WORD  bus read data; valid with busack_i.
REQ-018 mar_o, imdr_o, omdr_o, ir_o  output  WORD each  MAR, IMDR, OMDR, IR contents.
REQ-019 busy_o  output  1  access in progress; done_o  output  1  one-cycle completion pulse; err_o  output  1  one-cycle timeout pulse.

Function
REQ-020 FSM states: IDLE, ACCESS; IDLE -> ACCESS on start_i; ACCESS -> IDLE on busack_i or timeout.
REQ-021 In IDLE with start_i = 1, on the same edge: MAR <= addr_i; write/byte/fetch flags latched; wait counter <= 0.
REQ-022 On write start, OMDR <= wdata_i for word; byte: wdata_i[7:0] replicated into every lane.
REQ-023 On read start, OMDR unchanged.
REQ-024 In ACCESS: busreq_o = 1, busy_o = 1; busaddr_o, buswr_o, busbe_o, buswdata_o held constant for the whole access.
REQ-025 busaddr_o = MAR with bits [LSB-1:0] forced 0 on word access; full MAR on byte access.
REQ-026 busbe_o = all ones on word access; one-hot bit MAR[LSB-1:0] on byte access.
REQ-027 In IDLE: busreq_o = 0, buswr_o = 0, busbe_o = 0.
REQ-028 busack_i in ACCESS, read: IMDR <= busrdata_i (word) or the lane selected by MAR[LSB-1:0], zero-extended (byte).
REQ-029 busack_i in ACCESS, fetch: IR <= full busrdata_i; byte_i is ignored for fetches (always a word access).
REQ-030 busack_i in ACCESS, write: IMDR and IR unchanged.
REQ-031 done_o is registered: high exactly one cycle, the cycle after the busack_i cycle; IMDR/IR are valid in that same cycle.
REQ-032 Minimum latency: start_i in cycle 0, busreq_o high in cycle 1; ack in cycle 1 gives done_o in cycle 2.
REQ-033 Wait counter increments each ACCESS cycle without ack.
REQ-034 Timeout: when the counter reaches TO_CYC with no ack, err_o pulses next cycle and the FSM returns to IDLE; IMDR/IR unchanged.
REQ-035 Ack arriving in the same cycle the counter reaches TO_CYC is a success: no err_o.
REQ-036 start_i while in ACCESS is ignored (no queuing).
REQ-037 busack_i while in IDLE is ignored.
REQ-038 start_i in the done_o/err_o cycle (FSM in IDLE) is accepted normally (back-to-back).

Reset
REQ-039 rst_i = 1 at a clock edge: FSM <= IDLE, counter <= 0, MAR/IMDR/OMDR/IR <= 0, busy_o/done_o/err_o <= 0; all bus outputs 0.
REQ-040 Reset mid-access aborts the access: busreq_o low the next cycle, no done_o or err_o, and a later ack is ignored.
REQ-041 rst_i has priority over start_i and busack_i.

Structure
REQ-042 Package mem_access_pkg holds the FSM state enum and the access-flag struct (write, byte, fetch).
REQ-043 Sub-module mem_lane_align (combinational) provides byte enables, write-lane replication and read-lane extraction, and is parametrised by WORD.

Verification
REQ-044 Word read: addr 0x1235, ack after 3 wait cycles with rdata 0xBEEF -> busaddr 0x1234, be 2'b11, imdr 0xBEEF, done_o one cycle.
REQ-045 Byte write: addr 0x0101, wdata 0x00A5 -> be 2'b10, buswdata 0xA5A5, buswr_o 1, imdr unchanged.
REQ-046 Byte read at odd address, rdata 0x7F80 -> imdr 0x007F; fetch with rdata 0x4C21 -> ir 0x4C21, imdr 0x4C21.
REQ-047 No ack (TO_CYC 15) -> busreq_o high 15 cycles, err_o pulse, imdr unchanged; ack in cycle 15 -> done_o, no err_o.
REQ-048 Reset asserted in 2nd ACCESS cycle, then ack -> no done_o, all registers 0; back-to-back starts in done cycles accepted with no idle gap.
